// File: rtl/ship_rom_arbiter.sv
// ship_rom_arbiter: round-robin sharing of the tile ROM between two loaders.
// Each grant issues one 16-line burst and streams the lines back tagged.
module ship_rom_arbiter #(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [1:0]        tile0,
    output logic              ack0,
    output logic              done0,
    input  logic              req1,
    input  logic [1:0]        tile1,
    output logic              ack1,
    output logic              done1,
    output logic [6:0]        rom_addr,
    input  logic [LINE_W-1:0] rom_data,
    output logic              line_valid,
    output logic              line_owner,
    output logic [3:0]        line_idx,
    output logic [LINE_W-1:0] line_data,
    output logic              busy
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [3:0]    LAST_LINE  = 4'(NUM_LINES - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_grant;
    logic              w_gnt_id;
    logic              r_last;
    logic              r_owner;
    logic [1:0]        r_tile;
    logic [3:0]        r_cnt;
    logic [DW-1:0]     r_dcnt;
    logic [6:0]        r_addr;
    logic              r_v1;
    logic              r_v2;
    logic [3:0]        r_idx1;
    logic [3:0]        r_idx2;
    logic              r_lvalid;
    logic              r_lown;
    logic [3:0]        r_lidx;
    logic [LINE_W-1:0] r_ldata;
    logic              r_done0;
    logic              r_done1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_gnt_id = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_grant  = 1'b1;
                    // Contention goes to whoever was not served last
                    w_gnt_id = (req0 && req1) ? ~r_last : req1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_cnt == LAST_LINE) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_dcnt == LAST_DRAIN) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        busy = (r_state != S_IDLE);
        if (r_state == S_ISSUE && r_cnt == 4'd0) begin
            ack0 = ~r_owner;
            ack1 = r_owner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_tile   <= 2'd0;
            r_cnt    <= 4'd0;
            r_dcnt   <= '0;
            r_addr   <= 7'd0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_idx1   <= 4'd0;
            r_idx2   <= 4'd0;
            r_lvalid <= 1'b0;
            r_lown   <= 1'b0;
            r_lidx   <= 4'd0;
            r_ldata  <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
        end else begin
            r_v1 <= 1'b0;
            if (w_grant) begin
                r_owner <= w_gnt_id;
                r_last  <= w_gnt_id;
                r_tile  <= w_gnt_id ? tile1 : tile0;
                r_cnt   <= 4'd0;
            end
            if (r_state == S_ISSUE) begin
                r_addr <= {r_tile, 1'b0, r_cnt};
                r_v1   <= 1'b1;
                r_idx1 <= r_cnt;
                r_cnt  <= r_cnt + 4'd1;
            end
            if (r_state == S_DRAIN) begin
                r_dcnt <= r_dcnt + DW'(1);
            end else begin
                r_dcnt <= '0;
            end
            // Stage 2 lines up with the ROM's registered output
            r_v2     <= r_v1;
            r_idx2   <= r_idx1;
            r_lvalid <= r_v2;
            if (r_v2) begin
                r_lidx  <= r_idx2;
                r_ldata <= rom_data;
                r_lown  <= r_owner;
            end
            r_done0 <= r_v2 && (r_idx2 == LAST_LINE) && !r_owner;
            r_done1 <= r_v2 && (r_idx2 == LAST_LINE) && r_owner;
        end
    end

    assign rom_addr   = r_addr;
    assign line_valid = r_lvalid;
    assign line_owner = r_lown;
    assign line_idx   = r_lidx;
    assign line_data  = r_ldata;
    assign done0      = r_done0;
    assign done1      = r_done1;

endmodule

// File: tb/tb_ship_rom_arbiter.sv
// tb_ship_rom_arbiter: directed and random bursts checked against a
// timeline model counted in cycles from each grant.
`timescale 1ns/1ps
module tb_ship_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [1:0]  tile0 = 2'd0;
    logic [1:0]  tile1 = 2'd0;
    logic        ack0, ack1, done0, done1;
    logic        line_valid, line_owner, busy;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data = 32'd0;
    logic [31:0] line_data;
    logic [3:0]  line_idx;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ship_rom_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .tile0(tile0), .ack0(ack0), .done0(done0),
        .req1(req1), .tile1(tile1), .ack1(ack1), .done1(done1),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .line_valid(line_valid), .line_owner(line_owner),
        .line_idx(line_idx), .line_data(line_data), .busy(busy)
    );

    function automatic logic [31:0] rom_fn(input logic [6:0] a);
        logic [3:0] l;
        l = a[3:0];
        if (a[4]) return 32'hDEADBEEF;
        case (a[6:5])
            2'd0: return {16'hE0E0, 12'h000, l};
            2'd1: return 32'hFFFFFFFF;
            2'd2: begin
                if (l == 4'd0 || l == 4'd15) return 32'hFFFFFFFF;
                if (l == 4'd1) return 32'hF38001CF;
                if (l == 4'd8) return 32'hF003C00F;
                return {8'hF0, 4'h0, l, 12'h000, 4'hF};
            end
            default: begin
                if (l < 4'd2 || l > 4'd13) return 32'h0;
                if (l == 4'd2) return 32'h07FFFFE0;
                if (l == 4'd3) return 32'h070000E0;
                return {12'h070, l, 16'h00E0};
            end
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Model: m_t = cycles since the grant cycle, -1 when able to grant
    int          m_t = -1;
    logic        m_own = 1'b0;
    logic        m_last = 1'b1;
    logic [1:0]  m_tile = 2'd0;
    logic [6:0]  m_addr = 7'd0;
    logic        m_lown = 1'b0;
    logic [3:0]  m_lidx = 4'd0;
    logic [31:0] m_ldata = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = -1; m_last = 1'b1; m_own = 1'b0; m_tile = 2'd0;
            m_addr = 7'd0; m_lown = 1'b0; m_lidx = 4'd0; m_ldata = 32'd0;
        end else begin
            if (m_t < 0) begin
                if (req0 || req1) begin
                    m_own  = (req0 && req1) ? !m_last : req1;
                    m_last = m_own;
                    m_tile = m_own ? tile1 : tile0;
                    m_t    = 1;
                end
            end else begin
                m_t++;
                if (m_t == 20) m_t = -1;
            end
            if (m_t >= 2 && m_t <= 17) m_addr = {m_tile, 1'b0, 4'(m_t - 2)};
            if (m_t >= 4 && m_t <= 19) begin
                m_lidx  = 4'(m_t - 4);
                m_lown  = m_own;
                m_ldata = rom_fn({m_tile, 1'b0, m_lidx});
            end
        end
    end

    function automatic logic [49:0] exp_vec();
        return {m_t == 1 && !m_own, m_t == 1 && m_own,
                m_t == 19 && !m_own, m_t == 19 && m_own,
                m_t >= 1, m_t >= 4, m_lown, m_lidx, m_ldata, m_addr};
    endfunction

    function automatic logic [49:0] dut_vec();
        return {ack0, ack1, done0, done1, busy, line_valid,
                line_owner, line_idx, line_data, rom_addr};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== 50'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", dut_vec());
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec() || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ship();
        int ack_at = -1, done_at = -1, fall_at = -1, beats = 0;
        req0 = 1'b1; tile0 = 2'd1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ship_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (ack0) begin ack_at = c; req0 = 1'b0; end
            if (done0) done_at = c;
            if (ack_at >= 0 && fall_at < 0 && !busy) fall_at = c;
            if (line_valid) begin
                checks++;
                if (line_idx !== 4'(beats) || line_owner !== 1'b0 ||
                    line_data !== 32'hFFFFFFFF) begin
                    failures++;
                    $display("FAIL ship_beat n=%0d idx=%0d own=%b data=%h exp_idx=%0d",
                             beats, line_idx, line_owner, line_data, beats);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 16) begin failures++; $display("FAIL ship_beats got=%0d exp=16", beats); end
        checks++;
        if (done_at != ack_at + 18 || ack_at < 0) begin
            failures++;
            $display("FAIL ship_done_time got=%0d exp=%0d", done_at, ack_at + 18);
        end
        checks++;
        if (fall_at != ack_at + 19) begin
            failures++;
            $display("FAIL ship_busy_fall got=%0d exp=%0d", fall_at, ack_at + 19);
        end
    endtask

    task automatic test_hit();
        logic [31:0] d [16];
        int ack_at = -1, n_done0 = 0, n_done1 = 0;
        req1 = 1'b1; tile1 = 2'd2;
        for (int i = 0; i < 16; i++) d[i] = 32'h0BAD0BAD;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hit_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (ack1) begin ack_at = c; req1 = 1'b0; end
            if (done0) n_done0++;
            if (done1) n_done1++;
            if (ack_at >= 0 && c > ack_at && c <= ack_at + 16) begin
                checks++;
                if (rom_addr !== 7'(7'h40 + c - ack_at - 1)) begin
                    failures++;
                    $display("FAIL hit_addr got=%h exp=%h", rom_addr, 7'(7'h40 + c - ack_at - 1));
                end
            end
            if (line_valid) begin
                d[line_idx] = line_data;
                checks++;
                if (line_owner !== 1'b1) begin
                    failures++;
                    $display("FAIL hit_owner got=%b exp=1", line_owner);
                end
            end
        end
        checks++;
        if (d[0] !== 32'hFFFFFFFF || d[1] !== 32'hF38001CF ||
            d[8] !== 32'hF003C00F || d[15] !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL hit_lines got=%h %h %h %h exp=FFFFFFFF F38001CF F003C00F FFFFFFFF",
                     d[0], d[1], d[8], d[15]);
        end
        checks++;
        if (n_done1 != 1 || n_done0 != 0) begin
            failures++;
            $display("FAIL hit_done got=%0d/%0d exp=1/0", n_done1, n_done0);
        end
    endtask

    task automatic test_miss_switch();
        logic [31:0] d [16];
        int beats = 0;
        req0 = 1'b1; tile0 = 2'd3;
        for (int i = 0; i < 16; i++) d[i] = 32'h0BAD0BAD;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL miss_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (ack0) req0 = 1'b0;
            if (line_valid) begin
                d[line_idx] = line_data;
                beats++;
                checks++;
                if (line_data !== rom_fn({2'd3, 1'b0, line_idx})) begin
                    failures++;
                    $display("FAIL miss_beat idx=%0d got=%h exp=%h", line_idx,
                             line_data, rom_fn({2'd3, 1'b0, line_idx}));
                end
                if (line_idx == 4'd5) tile0 = 2'd1;
            end
        end
        checks++;
        if (d[0] !== 32'h0 || d[1] !== 32'h0 || d[14] !== 32'h0 || d[15] !== 32'h0 ||
            d[2] !== 32'h07FFFFE0 || d[3] !== 32'h070000E0 || beats != 16) begin
            failures++;
            $display("FAIL miss_lines got=%h %h %h %h %h %h n=%0d exp=0 0 0 0 07FFFFE0 070000E0 n=16",
                     d[0], d[1], d[14], d[15], d[2], d[3], beats);
        end
    endtask

    task automatic test_round_robin();
        int owners[$];
        int ack0_at = -1, ack1_at = -1;
        logic prev_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; tile0 = 2'd0; tile1 = 2'd3;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rr_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if ((ack0 || ack1) && prev_busy) begin
                checks++; failures++;
                $display("FAIL rr_ack_overlap c=%0d got=ack_while_busy exp=idle_before_ack", c);
            end
            if (ack0) begin owners.push_back(0); req0 = 1'b0; if (ack0_at < 0) ack0_at = c; end
            if (ack1) begin owners.push_back(1); req1 = 1'b0; if (ack1_at < 0) ack1_at = c; end
            if (done0) req0 = 1'b1;
            if (done1) req1 = 1'b1;
            prev_busy = busy;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (owners.size() < 4 || owners[0] != 0 || owners[1] != 1 ||
            owners[2] != 0 || owners[3] != 1) begin
            failures++;
            $display("FAIL rr_order got=%p exp=0,1,0,1", owners);
        end
        checks++;
        if (ack0_at < 0 || ack1_at != ack0_at + 20) begin
            failures++;
            $display("FAIL rr_ack1_time got=%0d exp=%0d", ack1_at, ack0_at + 20);
        end
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int hit5 = 0, bad = 0, beats = 0;
        req0 = 1'b1; tile0 = 2'd2;
        for (int c = 0; c < 30 && hit5 == 0; c++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (line_valid && line_idx == 4'd5) hit5 = 1;
        end
        checks++;
        if (hit5 == 0) begin failures++; $display("FAIL rmid_reach got=no_line5 exp=line5"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 50'd0) begin
            failures++;
            $display("FAIL rmid_async got=%h exp=0", dut_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (line_valid || done0 || done1 || busy) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rmid_quiet got=%0d exp=0", bad); end
        req0 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rmid_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (ack0) req0 = 1'b0;
            if (line_valid) begin
                if (line_idx !== 4'(beats) || line_data !== rom_fn({2'd2, 1'b0, 4'(beats)})) bad++;
                beats++;
            end
        end
        checks++;
        if (beats != 16 || bad != 0) begin
            failures++;
            $display("FAIL rmid_restart got=%0d beats %0d bad exp=16 beats 0 bad", beats, bad);
        end
    endtask

    task automatic test_stale_req1();
        int first = -1, second = -1, n_ack1 = 0, bad_own = 0;
        req0 = 1'b1; tile0 = 2'd0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stale_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (ack1) n_ack1++;
            if (line_valid && line_owner !== 1'b0) bad_own++;
            if (ack0) begin
                req0 = 1'b0;
                if (first < 0) first = c; else second = c;
            end
            if (first >= 0 && c == first + 5) req1 = 1'b1;
            if (first >= 0 && c == first + 6) req1 = 1'b0;
            if (first >= 0 && c == first + 10) req0 = 1'b1;
        end
        checks++;
        if (n_ack1 != 0 || bad_own != 0) begin
            failures++;
            $display("FAIL stale_req1 got=%0d acks %0d lines exp=0 0", n_ack1, bad_own);
        end
        checks++;
        if (first < 0 || second != first + 20) begin
            failures++;
            $display("FAIL stale_held_req0 got=%0d exp=%0d", second, first + 20);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_cycle c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (rst) rst = 1'b0;
            if (ack0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 5) == 0) req0 = 1'b1;
            else if (req0 && $urandom_range(0, 40) == 0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 5) == 0) req1 = 1'b1;
            else if (req1 && $urandom_range(0, 40) == 0) req1 = 1'b0;
            if ($urandom_range(0, 3) == 0) tile0 = 2'($urandom);
            if ($urandom_range(0, 3) == 0) tile1 = 2'($urandom);
            if (!rst && $urandom_range(0, 249) == 0) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (dut_vec() !== 50'd0) begin
                    failures++;
                    $display("FAIL rand_reset c=%0d got=%h exp=0", c, dut_vec());
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ship();
        test_hit();
        test_miss_switch();
        test_round_robin();
        test_reset_mid();
        test_stale_req1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
